// File: rtl/data_memory_sync.sv
// Single-port data memory with byte enables, valid/ready request port, a registered
// read response, and a hardware zero-clear sequence run after reset or on request.
module data_memory_sync #(
  parameter int unsigned DATA_W         = 16,
  parameter int unsigned ADDR_W         = 11,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [DATA_W/8-1:0]   req_be,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_data,
  output logic                  busy
);

  localparam int unsigned BYTES = DATA_W / 8;
  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_IDLE  = 1'b1
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   clr_cnt;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic                rd_accept;
  logic                wr_accept;

  // clr has priority: a request presented alongside it is never accepted
  always_comb begin
    req_ready = (state == S_IDLE) && !clr;
    busy      = (state == S_CLEAR);
    rd_accept = req_ready && req_valid && !req_we;
    wr_accept = req_ready && req_valid && req_we;
  end

  // Control state, clear counter and read response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;
      clr_cnt   <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      case (state)
        S_CLEAR: begin
          rsp_valid <= 1'b0;
          if (clr_cnt == LAST_ADDR) begin
            state <= S_IDLE;
          end else begin
            clr_cnt <= clr_cnt + ADDR_W'(1);
          end
        end
        S_IDLE: begin
          rsp_valid <= rd_accept;
          if (rd_accept) begin
            rsp_data <= mem[req_addr];
          end
          if (clr) begin
            clr_cnt <= '0;
            state   <= S_CLEAR;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Storage array is not reset; the clear sequence zeroes it one entry per cycle
  always_ff @(posedge clk) begin
    if (state == S_CLEAR) begin
      mem[clr_cnt] <= '0;
    end else if (wr_accept) begin
      for (int unsigned b = 0; b < BYTES; b++) begin
        if (req_be[b]) begin
          mem[req_addr][8*b +: 8] <= req_wdata[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_memory_sync.sv
// Self-checking bench for data_memory_sync: reset/clear timing, directed vector table,
// clr/reset corner sequences and randomised traffic against an array reference model.
module tb_data_memory_sync;

  localparam int unsigned DW    = 16;
  localparam int unsigned AW    = 11;
  localparam int unsigned DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clr;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [DW/8-1:0] req_be;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic          busy;

  int n_checks = 0;
  int n_pass   = 0;

  logic [DW-1:0] ref_mem [DEPTH];

  data_memory_sync #(
    .DATA_W(DW), .ADDR_W(AW), .CLEAR_ON_RESET(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_be(req_be), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          valid;
    logic          we;
    logic [1:0]    be;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          exp_v;
    logic [DW-1:0] exp_d;
  } vec_t;

  vec_t tbl [18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    clr = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_be = '0;
    req_addr = '0; req_wdata = '0;
  endtask

  // Counts edges until busy falls; expects a full DEPTH-cycle clear
  task automatic wait_clear(input string name);
    int n = 0;
    while (busy && n < 3 * DEPTH) begin
      chk({name, "_ready_low"}, 32'(req_ready), 32'd0);
      tick();
      n++;
    end
    chk({name, "_cycles"}, 32'(n), 32'(DEPTH));
    chk({name, "_ready_after"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] exp_data;
    logic          exp_valid;

    idle_inputs();
    rst_n = 1'b0;
    #12;
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    wait_clear("reset_clear");

    // Directed vectors: inputs applied for one edge, response checked just after it
    tbl[0]  = '{1'b1, 1'b0, 2'b00, 11'd0,    16'h0000, 1'b1, 16'h0000};
    tbl[1]  = '{1'b1, 1'b0, 2'b00, 11'd1023, 16'h0000, 1'b1, 16'h0000};
    tbl[2]  = '{1'b1, 1'b0, 2'b00, 11'd2047, 16'h0000, 1'b1, 16'h0000};
    tbl[3]  = '{1'b1, 1'b1, 2'b11, 11'd5,    16'hBEEF, 1'b0, 16'h0000};
    tbl[4]  = '{1'b1, 1'b0, 2'b00, 11'd5,    16'h0000, 1'b1, 16'hBEEF};
    tbl[5]  = '{1'b1, 1'b1, 2'b10, 11'd5,    16'h1200, 1'b0, 16'hBEEF};
    tbl[6]  = '{1'b1, 1'b0, 2'b00, 11'd5,    16'h0000, 1'b1, 16'h12EF};
    tbl[7]  = '{1'b1, 1'b1, 2'b11, 11'd1,    16'h0011, 1'b0, 16'h12EF};
    tbl[8]  = '{1'b1, 1'b1, 2'b11, 11'd2,    16'h0022, 1'b0, 16'h12EF};
    tbl[9]  = '{1'b1, 1'b1, 2'b11, 11'd3,    16'h0033, 1'b0, 16'h12EF};
    tbl[10] = '{1'b1, 1'b0, 2'b00, 11'd1,    16'h0000, 1'b1, 16'h0011};
    tbl[11] = '{1'b1, 1'b0, 2'b00, 11'd2,    16'h0000, 1'b1, 16'h0022};
    tbl[12] = '{1'b1, 1'b0, 2'b00, 11'd3,    16'h0000, 1'b1, 16'h0033};
    tbl[13] = '{1'b1, 1'b1, 2'b00, 11'd5,    16'hFFFF, 1'b0, 16'h0033};
    tbl[14] = '{1'b1, 1'b0, 2'b00, 11'd5,    16'h0000, 1'b1, 16'h12EF};
    tbl[15] = '{1'b1, 1'b1, 2'b01, 11'd9,    16'hABCD, 1'b0, 16'h12EF};
    tbl[16] = '{1'b0, 1'b0, 2'b00, 11'd9,    16'h0000, 1'b0, 16'h12EF};
    tbl[17] = '{1'b1, 1'b0, 2'b00, 11'd9,    16'h0000, 1'b1, 16'h00CD};

    for (int i = 0; i < 18; i++) begin
      req_valid = tbl[i].valid; req_we = tbl[i].we; req_be = tbl[i].be;
      req_addr = tbl[i].addr; req_wdata = tbl[i].wdata;
      #1;
      chk($sformatf("vec%0d_ready", i), 32'(req_ready), 32'd1);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_rsp_valid", i), 32'(rsp_valid), 32'(tbl[i].exp_v));
      chk($sformatf("vec%0d_rsp_data", i), 32'(rsp_data), 32'(tbl[i].exp_d));
    end
    idle_inputs();
    tick();
    chk("rsp_valid_pulse_end", 32'(rsp_valid), 32'd0);

    // clr together with a write to 7: write refused, full clear runs
    clr = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_be = 2'b11;
    req_addr = 11'd7; req_wdata = 16'h1234;
    #1;
    chk("clr_ready_low", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    idle_inputs();
    chk("clr_busy", 32'(busy), 32'd1);
    wait_clear("clr_clear");
    chk("clr_keeps_rsp_data", 32'(rsp_data), 32'h00CD);
    req_valid = 1'b1; req_addr = 11'd7;
    tick();
    chk("clr_read7_valid", 32'(rsp_valid), 32'd1);
    chk("clr_read7_data", 32'(rsp_data), 32'd0);
    req_addr = 11'd5;
    tick();
    chk("clr_read5_data", 32'(rsp_data), 32'd0);

    // Reset at clear cycle 1000, after a nonzero read response
    req_we = 1'b1; req_be = 2'b11; req_addr = 11'd7; req_wdata = 16'h5A5A;
    tick();
    req_we = 1'b0;
    tick();
    chk("pre_rst_read", 32'(rsp_data), 32'h5A5A);
    idle_inputs();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int i = 1; i < 1000; i++) tick();
    chk("mid_clear_busy", 32'(busy), 32'd1);
    chk("mid_clear_data_kept", 32'(rsp_data), 32'h5A5A);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("post_rst_rsp_data", 32'(rsp_data), 32'd0);
    wait_clear("rst_restart_clear");

    // Randomised traffic against byte-masked reference array (all zero after clear)
    for (int a = 0; a < int'(DEPTH); a++) ref_mem[a] = '0;
    exp_data = '0;
    for (int i = 0; i < 3000; i++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      req_we    = $urandom_range(0, 1) == 1;
      req_be    = 2'($urandom_range(0, 3));
      req_addr  = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(0, DEPTH - 1))
                                              : AW'($urandom_range(0, 31));
      req_wdata = DW'($urandom);
      exp_valid = req_valid && !req_we;
      if (exp_valid) exp_data = ref_mem[req_addr];
      if (req_valid && req_we) begin
        for (int b = 0; b < 2; b++)
          if (req_be[b]) ref_mem[req_addr][8*b +: 8] = req_wdata[8*b +: 8];
      end
      #1;
      if (req_ready !== 1'b1) chk($sformatf("rnd%0d_ready", i), 32'(req_ready), 32'd1);
      @(posedge clk);
      #1;
      chk($sformatf("rnd%0d_rsp_valid", i), 32'(rsp_valid), 32'(exp_valid));
      chk($sformatf("rnd%0d_rsp_data", i), 32'(rsp_data), 32'(exp_data));
    end
    idle_inputs();
    tick();
    chk("final_rsp_valid", 32'(rsp_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
